// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the unified single-ported memory shared by instruction
// fetch and the MEM stage; data accesses win because they belong to the older instruction.
module mem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  // data port
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  // memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_done_i,
  // pipeline control
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a requester raises its request and holds it (with stable
  // address/data) until its ack pulses for one cycle; memory sees a one-cycle
  // mem_req with address/data/we held until mem_done returns (one cycle).

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state_q;
  logic              owner_q;
  logic [7:0]        cnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic              err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      if_ack_q  <= 1'b0;
      dm_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dm_read_i || dm_write_i) begin
            state_q     <= GRANT;
            owner_q     <= OWN_DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_write_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
            // conflicting MemRead+MemWrite: the write is performed, flagged as error
            if (dm_read_i && dm_write_i) err_q <= 1'b1;
          end else if (if_req_i) begin
            state_q     <= GRANT;
            owner_q     <= OWN_FETCH;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
          end
        end
        GRANT: begin
          state_q <= BUSY;
          cnt_q   <= '0;
        end
        BUSY: begin
          if (mem_done_i) begin
            state_q <= RESP;
            if (owner_q == OWN_FETCH) begin
              if_rdata_q <= mem_rdata_i;
              if_ack_q   <= 1'b1;
            end else begin
              if (!mem_we_q) dm_rdata_q <= mem_rdata_i;
              dm_ack_q <= 1'b1;
            end
          end else if (cnt_q == TO_LAST) begin
            // memory never answered: complete with zero data so the pipe can move on
            state_q <= RESP;
            err_q   <= 1'b1;
            if (owner_q == OWN_FETCH) begin
              if_rdata_q <= '0;
              if_ack_q   <= 1'b1;
            end else begin
              if (!mem_we_q) dm_rdata_q <= '0;
              dm_ack_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

  assign stall_if_o  = if_req_i & ~if_ack_q;
  assign stall_mem_o = (dm_read_i | dm_write_i) & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts
// grant order, mem_req/ack cycles, held memory fields, read data and err.
module tb_mem_port_arbiter;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int T    = 16;
  localparam int NCYC = 4000;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          if_req, if_ack, dm_read, dm_write, dm_ack;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_done, stall_if, stall_mem, err;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_read_i(dm_read), .dm_write_i(dm_write), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_done_i(mem_done),
    .stall_if_o(stall_if), .stall_mem_o(stall_mem), .err_o(err),
    .dbg_state_o(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
  endtask

  // transaction-level model state
  bit            busy = 0;
  int            req_cyc = -1, done_cyc = -1, ack_cyc = -1, free_cyc = 0;
  int            rst_chk_cyc = -1, late_done_cyc = -1;
  bit            cur_data, cur_we, cur_both, cur_to;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [DW-1:0] if_rdata_m = '0, dm_rdata_m = '0;
  bit            err_m = 0;
  bit            if_infl = 0, dm_infl = 0;
  bit            exp_if_ack, exp_dm_ack, rst_now, phase2, in_window;
  int            c, lat, r;
  logic [DW-1:0] d;

  task automatic drop_owner();
    if (cur_data) begin dm_read = 0; dm_write = 0; end
    else if_req = 0;
  endtask

  initial begin
    rst = 1; if_req = 0; if_addr = '0; dm_read = 0; dm_write = 0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_done = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_if_ack", if_ack, 0);
    check_eq("rst_dm_ack", dm_ack, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_dm_rdata", dm_rdata, 0);
    check_eq("rst_err", err, 0);
    rst = 0;
    free_cyc = cyc;

    for (int k = 0; k < NCYC; k++) begin
      if (k != 0) @(negedge clk);
      c = cyc;
      phase2 = (k >= NCYC / 2);

      // expectations for this cycle
      if (c == req_cyc && cur_both) err_m = 1;
      if (c == ack_cyc && cur_to) err_m = 1;
      exp_if_ack = (c == ack_cyc) && !cur_data;
      exp_dm_ack = (c == ack_cyc) && cur_data;
      if (c == ack_cyc) begin
        if (cur_to) d = '0;
        else if (exp_q.size() == 0) begin
          check_eq("sb_nonempty", 0, 1);
          d = '0;
        end else d = exp_q.pop_front();
        if (!cur_data) if_rdata_m = d;
        else if (!cur_we) dm_rdata_m = d;
      end

      check_eq("mem_req", mem_req, 64'(c == req_cyc));
      check_eq("if_ack", if_ack, 64'(exp_if_ack));
      check_eq("dm_ack", dm_ack, 64'(exp_dm_ack));
      check_eq("if_rdata", if_rdata, if_rdata_m);
      check_eq("dm_rdata", dm_rdata, dm_rdata_m);
      check_eq("err", err, 64'(err_m));
      if (busy && c >= req_cyc && c < ack_cyc) begin
        check_eq("mem_we", mem_we, 64'(cur_we));
        check_eq("mem_addr", mem_addr, cur_addr);
        if (cur_we) check_eq("mem_wdata", mem_wdata, cur_wdata);
      end
      if (c == rst_chk_cyc) begin
        check_eq("rst_mid_we", mem_we, 0);
        check_eq("rst_mid_addr", mem_addr, 0);
        check_eq("rst_mid_wdata", mem_wdata, 0);
      end

      // drive next inputs
      if (c == ack_cyc) begin
        busy = 0;
        drop_owner();
        if (cur_data) dm_infl = 0; else if_infl = 0;
      end
      rst_now = phase2 && busy && c > req_cyc && c < ack_cyc && ($urandom_range(0, 149) == 0);
      if (rst_now) begin
        rst = 1;
        busy = 0; req_cyc = -1; done_cyc = -1; ack_cyc = -1;
        if_req = 0; dm_read = 0; dm_write = 0; if_infl = 0; dm_infl = 0;
        exp_q.delete();
        if_rdata_m = '0; dm_rdata_m = '0; err_m = 0;
        rst_chk_cyc = c + 1; late_done_cyc = c + 2; free_cyc = c + 1;
      end else begin
        rst = 0;
        if (busy && c >= req_cyc && c < ack_cyc - 1 && ($urandom_range(0, 15) == 0))
          drop_owner();
        if (!if_req && !if_infl && ($urandom_range(0, 2) == 0)) begin
          if_req = 1;
          if_addr = {$urandom, $urandom};
        end
        if (!dm_read && !dm_write && !dm_infl && ($urandom_range(0, 3) == 0)) begin
          r = $urandom_range(0, 7);
          if (phase2 && r == 0) begin dm_read = 1; dm_write = 1; end
          else if (r < 4) dm_read = 1;
          else dm_write = 1;
          dm_addr = {$urandom, $urandom};
          dm_wdata = {$urandom, $urandom};
        end
        if (!busy && c >= free_cyc && (if_req || dm_read || dm_write)) begin
          busy = 1;
          req_cyc = c + 1;
          cur_data = dm_read | dm_write;
          cur_both = dm_read & dm_write;
          cur_we = cur_data ? dm_write : 1'b0;
          cur_addr = cur_data ? dm_addr : if_addr;
          cur_wdata = dm_wdata;
          cur_to = phase2 && ($urandom_range(0, 9) == 0);
          lat = $urandom_range(1, 6);
          done_cyc = cur_to ? -1 : c + 1 + lat;
          ack_cyc = cur_to ? c + 2 + T : c + 2 + lat;
          free_cyc = ack_cyc + 1;
          if (cur_data) dm_infl = 1; else if_infl = 1;
        end
      end

      // memory responder, with stray mem_done outside the BUSY window
      in_window = busy && c > req_cyc && c < ack_cyc;
      mem_rdata = {$urandom, $urandom};
      mem_done = (c == done_cyc) || (c == late_done_cyc) ||
                 (!in_window && ($urandom_range(0, 7) == 0));
      if (c == done_cyc) exp_q.push_back(mem_rdata);

      #1;
      check_eq("stall_if", stall_if, 64'(if_req & ~exp_if_ack));
      check_eq("stall_mem", stall_mem, 64'((dm_read | dm_write) & ~exp_dm_ack));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
